conv_layer_seq: RTL and testbench

//  Parametrised sequencer for one conv+pool layer of the LeNet-5 datapath. It loads an
//  IN_CH-plane input map from the previous layer's buffers, then loops over output-channel

---
 rtl/conv_layer_seq.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_conv_layer_seq.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_seq.sv
// conv_layer_seq: sequencer for one conv+pool layer of the LeNet-5 datapath.
// Loads an IN_CH-plane input map into the local buffer, then, for each group of
// PAR output channels, loads weights, sweeps the window and drains the pipeline.
// Optional feature macro: CONV_LAYER_SEQ_PERF_EN adds a 32-bit perf_cycles
// counter of busy cycles per layer run.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for en
// LOAD_INP | streaming the input map into the local buffer
// LOAD_W   | streaming one group's weights (plus bias) into the lanes
// CONV     | issuing window positions to the MAC arrays
// DRAIN    | fixed wait for MAC/pool pipelines to empty
// DONE     | layer finished, held until en drops

module conv_layer_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_W       = 14,
  parameter int IN_H       = 14,
  parameter int IN_CH      = 6,
  parameter int K          = 5,
  parameter int OUT_CH     = 16,
  parameter int PAR        = 2,
  parameter int RD_LAT     = 2,
  parameter int DRAIN_CYC  = 10,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              busy,
  output logic              done,
  output logic              feat_rd,
  output logic [ADDR_W-1:0] feat_addr,
  output logic              buf_we,
  output logic [3:0]        buf_row,
  output logic [3:0]        buf_col,
  output logic              w_rd,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_we,
  output logic [ADDR_W-1:0] w_idx,
  output logic              win_valid,
  output logic [3:0]        win_row,
  output logic [3:0]        win_col,
  output logic              cal_start,
  output logic [ADDR_W-1:0] pool_base,
  output logic [4:0]        grp
`ifdef CONV_LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int OUT_W   = IN_W - K + 1;
  localparam int OUT_H   = IN_H - K + 1;
  localparam int N_IN    = IN_W * IN_H;
  localparam int FSZ     = IN_CH * K * K + 1;
  localparam int NGRP    = OUT_CH / PAR;
  localparam int POOL_SZ = (OUT_W / 2) * (OUT_H / 2);
  localparam int DW      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  // Elaboration-time sanity checks on the parameter set.
  if (OUT_CH % PAR != 0) begin : g_bad_par
    $error("conv_layer_seq: OUT_CH must be a multiple of PAR");
  end
  if (NGRP * FSZ >= (1 << ADDR_W)) begin : g_bad_waddr
    $error("conv_layer_seq: weight address space overflows ADDR_W");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("conv_layer_seq: RD_LAT must be 1..3");
  end
  if (DATA_WIDTH < 1 || DRAIN_CYC < 1) begin : g_bad_misc
    $error("conv_layer_seq: DATA_WIDTH and DRAIN_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_INP,
    S_LOAD_W,
    S_CONV,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [3:0]        rd_row;
  logic [ADDR_W-1:0] rd_col;
  logic [ADDR_W-1:0] w_ridx;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] win_r;
  logic [ADDR_W-1:0] win_c;
  logic [DW-1:0]     drain_cnt;

  // Read-latency pipelines: strobe, last-beat flag and write position.
  logic              fp_v    [RD_LAT];
  logic              fp_last [RD_LAT];
  logic [3:0]        fp_row  [RD_LAT];
  logic [3:0]        fp_col  [RD_LAT];
  logic              wp_v    [RD_LAT];
  logic              wp_last [RD_LAT];
  logic [ADDR_W-1:0] wp_idx  [RD_LAT];

  logic abort;
  logic buf_last;
  logic w_last;

  assign abort    = (state != S_IDLE) && !en;
  assign buf_we   = fp_v[RD_LAT-1];
  assign buf_last = fp_last[RD_LAT-1];
  assign buf_row  = fp_row[RD_LAT-1];
  assign buf_col  = fp_col[RD_LAT-1];
  assign w_we     = wp_v[RD_LAT-1];
  assign w_last   = wp_last[RD_LAT-1];
  assign w_idx    = wp_idx[RD_LAT-1];
  assign win_row  = win_r[3:0];
  assign win_col  = win_c[3:0];

  // Delay the read strobes by RD_LAT to form the write strobes; abort flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        fp_v[i]    <= 1'b0;
        fp_last[i] <= 1'b0;
        fp_row[i]  <= '0;
        fp_col[i]  <= '0;
        wp_v[i]    <= 1'b0;
        wp_last[i] <= 1'b0;
        wp_idx[i]  <= '0;
      end
    end else if (abort) begin
      for (int i = 0; i < RD_LAT; i++) begin
        fp_v[i]    <= 1'b0;
        fp_last[i] <= 1'b0;
        fp_row[i]  <= '0;
        fp_col[i]  <= '0;
        wp_v[i]    <= 1'b0;
        wp_last[i] <= 1'b0;
        wp_idx[i]  <= '0;
      end
    end else begin
      fp_v[0]    <= feat_rd;
      fp_last[0] <= feat_rd && (feat_addr == ADDR_W'(N_IN - 1));
      fp_row[0]  <= rd_row;
      fp_col[0]  <= rd_col[3:0];
      wp_v[0]    <= w_rd;
      wp_last[0] <= w_rd && (w_ridx == ADDR_W'(FSZ - 1));
      wp_idx[0]  <= w_ridx;
      for (int i = 1; i < RD_LAT; i++) begin
        fp_v[i]    <= fp_v[i-1];
        fp_last[i] <= fp_last[i-1];
        fp_row[i]  <= fp_row[i-1];
        fp_col[i]  <= fp_col[i-1];
        wp_v[i]    <= wp_v[i-1];
        wp_last[i] <= wp_last[i-1];
        wp_idx[i]  <= wp_idx[i-1];
      end
    end
  end

  // Main layer FSM with registered strobes, addresses and group bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      feat_rd   <= 1'b0;
      feat_addr <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      w_rd      <= 1'b0;
      w_addr    <= '0;
      w_ridx    <= '0;
      w_base    <= '0;
      win_valid <= 1'b0;
      win_r     <= '0;
      win_c     <= '0;
      cal_start <= 1'b0;
      pool_base <= '0;
      grp       <= '0;
      drain_cnt <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      feat_rd   <= 1'b0;
      feat_addr <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      w_rd      <= 1'b0;
      w_addr    <= '0;
      w_ridx    <= '0;
      w_base    <= '0;
      win_valid <= 1'b0;
      win_r     <= '0;
      win_c     <= '0;
      cal_start <= 1'b0;
      pool_base <= '0;
      grp       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            state     <= S_LOAD_INP;
            busy      <= 1'b1;
            feat_rd   <= 1'b1;
            feat_addr <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
            grp       <= '0;
            pool_base <= '0;
            w_base    <= '0;
          end
        end
        S_LOAD_INP: begin
          if (feat_rd) begin
            if (feat_addr == ADDR_W'(N_IN - 1)) begin
              feat_rd <= 1'b0;
            end else begin
              feat_addr <= feat_addr + 1'b1;
              if (rd_col == ADDR_W'(IN_W - 1)) begin
                rd_col <= '0;
                rd_row <= rd_row + 1'b1;
              end else begin
                rd_col <= rd_col + 1'b1;
              end
            end
          end
          if (buf_we && buf_last) begin
            state  <= S_LOAD_W;
            w_rd   <= 1'b1;
            w_addr <= w_base;
            w_ridx <= '0;
          end
        end
        S_LOAD_W: begin
          if (w_rd) begin
            if (w_ridx == ADDR_W'(FSZ - 1)) begin
              w_rd <= 1'b0;
            end else begin
              w_ridx <= w_ridx + 1'b1;
              w_addr <= w_addr + 1'b1;
            end
          end
          if (w_we && w_last) begin
            state     <= S_CONV;
            win_valid <= 1'b1;
            win_r     <= '0;
            win_c     <= '0;
            cal_start <= 1'b1;
          end
        end
        S_CONV: begin
          cal_start <= 1'b0;
          if (win_c == ADDR_W'(OUT_W - 1)) begin
            win_c <= '0;
            if (win_r == ADDR_W'(OUT_H - 1)) begin
              win_r     <= '0;
              win_valid <= 1'b0;
              state     <= S_DRAIN;
              drain_cnt <= DW'(DRAIN_CYC - 1);
            end else begin
              win_r <= win_r + 1'b1;
            end
          end else begin
            win_c <= win_c + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            if (grp == 5'(NGRP - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              grp       <= grp + 1'b1;
              pool_base <= pool_base + ADDR_W'(POOL_SZ);
              w_base    <= w_base + ADDR_W'(FSZ);
              w_addr    <= w_base + ADDR_W'(FSZ);
              w_ridx    <= '0;
              w_rd      <= 1'b1;
              state     <= S_LOAD_W;
            end
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_LAYER_SEQ_PERF_EN
  // Busy-cycle counter: cleared at layer start, frozen in DONE and IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
    end else if (state == S_IDLE && en) begin
      perf_cycles <= '0;
    end else if (busy && state != S_DONE) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_layer_seq.sv
// Bench for conv_layer_seq: default-parameter instance plus a 32x32 / PAR=3 /
// RD_LAT=1 instance; expected address streams are queued when en is raised and
// popped as the DUT emits strobes.
module tb_conv_layer_seq;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rst, en, en_p;
  int checks = 0;
  int errors = 0;

  logic          busy, done, feat_rd, buf_we, w_rd, w_we, win_valid, cal_start;
  logic [AW-1:0] feat_addr, w_addr, w_idx, pool_base;
  logic [3:0]    buf_row, buf_col, win_row, win_col;
  logic [4:0]    grp;
  logic          p_busy, p_done, p_feat_rd, p_buf_we, p_w_rd, p_w_we, p_win_valid, p_cal_start;
  logic [AW-1:0] p_feat_addr, p_w_addr, p_w_idx, p_pool_base;
  logic [3:0]    p_buf_row, p_buf_col, p_win_row, p_win_col;
  logic [4:0]    p_grp;
`ifdef CONV_LAYER_SEQ_PERF_EN
  logic [31:0]   perf_cycles, p_perf_cycles;
`endif

  conv_layer_seq u_d (
    .clk(clk), .rst(rst), .en(en), .busy(busy), .done(done),
    .feat_rd(feat_rd), .feat_addr(feat_addr), .buf_we(buf_we),
    .buf_row(buf_row), .buf_col(buf_col), .w_rd(w_rd), .w_addr(w_addr),
    .w_we(w_we), .w_idx(w_idx), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .cal_start(cal_start), .pool_base(pool_base), .grp(grp)
`ifdef CONV_LAYER_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  conv_layer_seq #(
    .IN_W(32), .IN_H(32), .IN_CH(1), .OUT_CH(6), .PAR(3), .RD_LAT(1)
  ) u_p (
    .clk(clk), .rst(rst), .en(en_p), .busy(p_busy), .done(p_done),
    .feat_rd(p_feat_rd), .feat_addr(p_feat_addr), .buf_we(p_buf_we),
    .buf_row(p_buf_row), .buf_col(p_buf_col), .w_rd(p_w_rd), .w_addr(p_w_addr),
    .w_we(p_w_we), .w_idx(p_w_idx), .win_valid(p_win_valid), .win_row(p_win_row),
    .win_col(p_win_col), .cal_start(p_cal_start), .pool_base(p_pool_base), .grp(p_grp)
`ifdef CONV_LAYER_SEQ_PERF_EN
    , .perf_cycles(p_perf_cycles)
`endif
  );

  task automatic test_reset();
    bit hit = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, feat_rd, buf_we, w_rd, w_we, win_valid, cal_start} !== 8'h00) begin
      errors++; $display("FAIL reset strobes: got %b expected 00000000",
        {busy, done, feat_rd, buf_we, w_rd, w_we, win_valid, cal_start});
    end
    checks++;
    if ({feat_addr, w_addr, w_idx, pool_base, grp} !== '0) begin
      errors++; $display("FAIL reset values: feat_addr %0d w_addr %0d pool_base %0d grp %0d, expected all 0",
        feat_addr, w_addr, pool_base, grp);
    end
    rst = 1'b1;
    en  = 1'b1;
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk);
      if (win_valid) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reset reach CONV: got timeout expected win_valid"); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, feat_rd, buf_we, w_rd, w_we, win_valid, cal_start} !== 8'h00) begin
      errors++; $display("FAIL midrun reset strobes: got %b expected 00000000",
        {busy, done, feat_rd, buf_we, w_rd, w_we, win_valid, cal_start});
    end
    checks++;
    if ({feat_addr, w_addr, w_idx, pool_base, grp, buf_row, buf_col, win_row, win_col} !== '0) begin
      errors++; $display("FAIL midrun reset values: w_addr %0d win %0d,%0d grp %0d, expected all 0",
        w_addr, win_row, win_col, grp);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, feat_rd} !== 2'b00) begin
      errors++; $display("FAIL reset release idle: got busy/feat_rd %b expected 00", {busy, feat_rd});
    end
  endtask

  task automatic test_full_run();
    int q_feat[$], q_buf[$], q_w[$], q_widx[$], q_win[$];
    int n_feat = 0, n_buf = 0, n_w = 0, n_wwe = 0, n_win = 0, busy_bad = 0;
    int first_feat = -1, first_buf = -1, last_buf_cyc = -1, gap_bw = -1;
    int last_wwe_cyc = -1, gap_cw = -1, last_win_cyc = -1, gap_g1 = -1;
    int n_w_g3 = 0, w_g3_first = -1, w_g3_last = -1, cal_g3 = 0, pool_g3 = -1, last_w = -1;
    int expv, gotv;
    bit done_seen = 0;
    for (int a = 0; a < 196; a++) q_feat.push_back(a);
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++) q_buf.push_back(r * 16 + c);
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < 151; i++) begin
        q_w.push_back(g * 151 + i);
        q_widx.push_back(i);
      end
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 10; c++)
          q_win.push_back((g << 21) | ((g * 25) << 9) | (((r == 0 && c == 0) ? 1 : 0) << 8) | (r << 4) | c);
    end
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 6000 && !done_seen; k++) begin
      @(negedge clk);
      if (feat_rd) begin
        n_feat++;
        if (first_feat < 0) first_feat = cyc;
        if (q_feat.size() > 0) expv = q_feat.pop_front(); else expv = -1;
        checks++;
        if (int'(feat_addr) !== expv) begin
          errors++; $display("FAIL feat_addr seq: got %0d expected %0d", feat_addr, expv);
        end
      end
      if (buf_we) begin
        n_buf++;
        if (first_buf < 0) first_buf = cyc;
        last_buf_cyc = cyc;
        if (q_buf.size() > 0) expv = q_buf.pop_front(); else expv = -1;
        gotv = int'({buf_row, buf_col});
        checks++;
        if (gotv !== expv) begin
          errors++; $display("FAIL buf row/col: got %0d,%0d expected %0d,%0d",
            buf_row, buf_col, expv / 16, expv % 16);
        end
      end
      if (w_rd) begin
        n_w++;
        if (gap_bw < 0) gap_bw = cyc - last_buf_cyc;
        if (int'(w_addr) == 151 && gap_g1 < 0) gap_g1 = cyc - last_win_cyc;
        last_w = int'(w_addr);
        if (grp == 5'd3) begin
          n_w_g3++;
          if (w_g3_first < 0) w_g3_first = int'(w_addr);
          w_g3_last = int'(w_addr);
        end
        if (q_w.size() > 0) expv = q_w.pop_front(); else expv = -1;
        checks++;
        if (int'(w_addr) !== expv) begin
          errors++; $display("FAIL w_addr seq: got %0d expected %0d", w_addr, expv);
        end
      end
      if (w_we) begin
        n_wwe++;
        last_wwe_cyc = cyc;
        if (q_widx.size() > 0) expv = q_widx.pop_front(); else expv = -1;
        checks++;
        if (int'(w_idx) !== expv) begin
          errors++; $display("FAIL w_idx seq: got %0d expected %0d", w_idx, expv);
        end
      end
      if (win_valid) begin
        n_win++;
        if (gap_cw < 0) gap_cw = cyc - last_wwe_cyc;
        last_win_cyc = cyc;
        if (cal_start && grp == 5'd3) begin
          cal_g3++;
          pool_g3 = int'(pool_base);
        end
        if (q_win.size() > 0) expv = q_win.pop_front(); else expv = -1;
        gotv = int'({grp, pool_base, cal_start, win_row, win_col});
        checks++;
        if (gotv !== expv) begin
          errors++; $display("FAIL window seq: got grp/pool/cal/row/col %0d/%0d/%0d/%0d/%0d raw %0h expected raw %0h",
            grp, pool_base, cal_start, win_row, win_col, gotv, expv);
        end
      end
      if (!busy) busy_bad++;
      if (done) done_seen = 1;
    end
    checks++;
    if (!done_seen) begin errors++; $display("FAIL full run done: got timeout expected done"); end
    checks++;
    if (n_feat != 196 || n_buf != 196) begin
      errors++; $display("FAIL load counts: got feat_rd %0d buf_we %0d expected 196 196", n_feat, n_buf);
    end
    checks++;
    if (first_buf - first_feat != 2) begin
      errors++; $display("FAIL buf_we latency: got %0d expected 2", first_buf - first_feat);
    end
    checks++;
    if (n_w != 1208 || n_wwe != 1208 || n_win != 800) begin
      errors++; $display("FAIL group counts: got w_rd %0d w_we %0d win %0d expected 1208 1208 800", n_w, n_wwe, n_win);
    end
    checks++;
    if (last_w != 1207 || pool_base !== 12'd175 || grp !== 5'd7) begin
      errors++; $display("FAIL final group: got w_addr %0d pool_base %0d grp %0d expected 1207 175 7", last_w, pool_base, grp);
    end
    checks++;
    if (q_feat.size() + q_buf.size() + q_w.size() + q_widx.size() + q_win.size() != 0) begin
      errors++; $display("FAIL scoreboard leftovers: got %0d expected 0",
        q_feat.size() + q_buf.size() + q_w.size() + q_widx.size() + q_win.size());
    end
    checks++;
    if (gap_bw != 1 || gap_cw != 1 || gap_g1 != 11) begin
      errors++; $display("FAIL phase gaps: got buf->w %0d w->win %0d win->w %0d expected 1 1 11", gap_bw, gap_cw, gap_g1);
    end
    checks++;
    if (n_w_g3 != 151 || w_g3_first != 453 || w_g3_last != 603) begin
      errors++; $display("FAIL group3 weights: got n %0d first %0d last %0d expected 151 453 603", n_w_g3, w_g3_first, w_g3_last);
    end
    checks++;
    if (cal_g3 != 1 || pool_g3 != 75) begin
      errors++; $display("FAIL group3 window: got cal_start %0d pool_base %0d expected 1 75", cal_g3, pool_g3);
    end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL busy during run: got %0d idle cycles expected 0", busy_bad); end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b11) begin errors++; $display("FAIL done hold: got busy/done %b expected 11", {busy, done}); end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, grp} !== 7'd0) begin
      errors++; $display("FAIL done exit: got busy %b done %b grp %0d expected 0 0 0", busy, done, grp);
    end
  endtask

  task automatic test_abort();
    bit hit = 0;
    int nstray = 0;
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 3000 && !hit; k++) begin
      @(negedge clk);
      if (w_rd && grp == 5'd2 && w_addr == 12'd322) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort reach group2: got timeout expected LOAD_W grp 2"); end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, w_rd, w_we, grp} !== 8'd0) begin
      errors++; $display("FAIL abort idle: got busy %b w_rd %b w_we %b grp %0d expected 0 0 0 0", busy, w_rd, w_we, grp);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (w_we || buf_we || w_rd || feat_rd || busy) nstray++;
    end
    checks++;
    if (nstray != 0) begin errors++; $display("FAIL abort flush: got %0d stray cycles expected 0", nstray); end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if ({feat_rd, busy} !== 2'b11 || feat_addr !== 12'd0 || grp !== 5'd0) begin
      errors++; $display("FAIL rerun start: got feat_rd %b feat_addr %0d grp %0d expected 1 0 0", feat_rd, feat_addr, grp);
    end
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort in LOAD_INP: got busy %b expected 0", busy); end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (feat_rd !== 1'b1 || feat_addr !== 12'd0) begin
      errors++; $display("FAIL immediate restart: got feat_rd %b feat_addr %0d expected 1 0", feat_rd, feat_addr);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_param_run();
    int q_feat[$], q_w[$];
    int n_feat = 0, n_buf = 0, n_w = 0, n_w0 = 0, n_win = 0, n_win0 = 0;
    int first_feat = -1, first_buf = -1, last_w = -1, expv;
    bit done_seen = 0;
    for (int a = 0; a < 1024; a++) q_feat.push_back(a);
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 26; i++) q_w.push_back(g * 26 + i);
    @(negedge clk);
    en_p = 1'b1;
    for (int k = 0; k < 8000 && !done_seen; k++) begin
      @(negedge clk);
      if (p_feat_rd) begin
        n_feat++;
        if (first_feat < 0) first_feat = cyc;
        if (q_feat.size() > 0) expv = q_feat.pop_front(); else expv = -1;
        checks++;
        if (int'(p_feat_addr) !== expv) begin
          errors++; $display("FAIL param feat_addr: got %0d expected %0d", p_feat_addr, expv);
        end
      end
      if (p_buf_we) begin
        n_buf++;
        if (first_buf < 0) first_buf = cyc;
      end
      if (p_w_rd) begin
        n_w++;
        if (p_grp == 5'd0) n_w0++;
        last_w = int'(p_w_addr);
        if (q_w.size() > 0) expv = q_w.pop_front(); else expv = -1;
        checks++;
        if (int'(p_w_addr) !== expv) begin
          errors++; $display("FAIL param w_addr: got %0d expected %0d", p_w_addr, expv);
        end
      end
      if (p_win_valid) begin
        n_win++;
        if (p_grp == 5'd0) n_win0++;
      end
      if (p_done) done_seen = 1;
    end
    checks++;
    if (!done_seen) begin errors++; $display("FAIL param done: got timeout expected done"); end
    checks++;
    if (n_feat != 1024 || n_buf != 1024 || first_buf - first_feat != 1) begin
      errors++; $display("FAIL param load: got feat %0d buf %0d lat %0d expected 1024 1024 1",
        n_feat, n_buf, first_buf - first_feat);
    end
    checks++;
    if (n_w != 52 || n_w0 != 26 || last_w != 51) begin
      errors++; $display("FAIL param weights: got total %0d grp0 %0d last %0d expected 52 26 51", n_w, n_w0, last_w);
    end
    checks++;
    if (n_win != 1568 || n_win0 != 784 || p_grp !== 5'd1 || p_pool_base !== 12'd196) begin
      errors++; $display("FAIL param windows: got total %0d grp0 %0d grp %0d pool %0d expected 1568 784 1 196",
        n_win, n_win0, p_grp, p_pool_base);
    end
    en_p = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (p_busy !== 1'b0) begin errors++; $display("FAIL param exit: got busy %b expected 0", p_busy); end
  endtask

`ifdef CONV_LAYER_SEQ_PERF_EN
  task automatic test_perf();
    int nbusy = 0;
    bit done_seen = 0;
    logic [31:0] at_done;
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 6000 && !done_seen; k++) begin
      @(negedge clk);
      if (done) done_seen = 1;
      else if (busy) nbusy++;
    end
    at_done = perf_cycles;
    checks++;
    if (!done_seen || int'(at_done) != nbusy) begin
      errors++; $display("FAIL perf at done: got %0d expected %0d", at_done, nbusy);
    end
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (int'(perf_cycles) != nbusy) begin
      errors++; $display("FAIL perf hold: got %0d expected %0d", perf_cycles, nbusy);
    end
  endtask
`endif

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    en_p = 1'b0;
    test_reset();
    test_full_run();
    test_abort();
    test_param_run();
`ifdef CONV_LAYER_SEQ_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
